// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator producing coordinates, data-enable, syncs,
// frame/line markers, frame counter and a per-frame latched pattern mode.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int SYNC_DLY = 1
) (
    input  logic       clk_pix,
    input  logic       resetn,
    input  logic       en,
    input  logic [1:0] mode_req,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       sof,
    output logic       eol,
    output logic [1:0] mode,
    output logic [7:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024");
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 3) begin : g_bad_dly
        $error("vga_sync_gen: SYNC_DLY must be 0..3");
    end

    logic [9:0]        h_ctr, v_ctr;
    logic              first;
    logic              h_last, at_sof, hs_raw, vs_raw;
    logic [SYNC_DLY:0] hs_sr, vs_sr;

    assign h_last = h_ctr == H_MAX;
    assign at_sof = h_ctr == '0 && v_ctr == '0;
    assign hs_raw = (h_ctr >= HS_BEG && h_ctr < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = (v_ctr >= VS_BEG && v_ctr < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign hsync  = hs_sr[SYNC_DLY];
    assign vsync  = vs_sr[SYNC_DLY];

    always_ff @(posedge clk_pix) begin
        if (!resetn) begin
            h_ctr     <= '0;
            v_ctr     <= '0;
            hcount    <= '0;
            vcount    <= '0;
            de        <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            mode      <= '0;
            frame_cnt <= '0;
            first     <= 1'b1;
            hs_sr     <= {(SYNC_DLY + 1){~SYNC_POL}};
            vs_sr     <= {(SYNC_DLY + 1){~SYNC_POL}};
        end else if (en) begin
            h_ctr  <= h_last ? '0 : h_ctr + 10'd1;
            if (h_last)
                v_ctr <= (v_ctr == V_MAX) ? '0 : v_ctr + 10'd1;
            hcount <= h_ctr;
            vcount <= v_ctr;
            de     <= h_ctr < H_ACT && v_ctr < V_ACT;
            sof    <= at_sof;
            eol    <= h_last;
            // the first sof after reset is frame 0, later ones advance the index
            if (at_sof) begin
                mode      <= mode_req;
                frame_cnt <= first ? frame_cnt : frame_cnt + 8'd1;
                first     <= 1'b0;
            end
            hs_sr[0] <= hs_raw;
            vs_sr[0] <= vs_raw;
            for (int i = SYNC_DLY; i > 0; i--) begin
                hs_sr[i] <= hs_sr[i-1];
                vs_sr[i] <= vs_sr[i-1];
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks on a full 640x480 instance (line-level timing)
// and a tiny 15x10 raster instance (frame-level behaviour, SYNC_DLY=0, active-high syncs).
module tb_vga_sync_gen;
    logic       clk_pix = 1'b0;
    logic       resetn, en_a, en_b;
    logic [1:0] mode_req;
    logic [9:0] a_hcount, a_vcount, b_hcount, b_vcount;
    logic       a_de, a_hsync, a_vsync, a_sof, a_eol;
    logic       b_de, b_hsync, b_vsync, b_sof, b_eol;
    logic [1:0] a_mode, b_mode;
    logic [7:0] a_frame_cnt, b_frame_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_pix = ~clk_pix;

    vga_sync_gen dut_a (
        .clk_pix(clk_pix), .resetn(resetn), .en(en_a), .mode_req(mode_req),
        .hcount(a_hcount), .vcount(a_vcount), .de(a_de), .hsync(a_hsync), .vsync(a_vsync),
        .sof(a_sof), .eol(a_eol), .mode(a_mode), .frame_cnt(a_frame_cnt)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .SYNC_DLY(0)
    ) dut_b (
        .clk_pix(clk_pix), .resetn(resetn), .en(en_b), .mode_req(mode_req),
        .hcount(b_hcount), .vcount(b_vcount), .de(b_de), .hsync(b_hsync), .vsync(b_vsync),
        .sof(b_sof), .eol(b_eol), .mode(b_mode), .frame_cnt(b_frame_cnt)
    );

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; en_a = 1'b1; en_b = 1'b1; mode_req = 2'd1;
        step(); step();
        n_cmp++; if ({a_hcount, a_vcount} !== 20'd0) begin n_bad++; $display("FAIL rst_a_cnt got %0d/%0d want 0/0", a_hcount, a_vcount); end
        n_cmp++; if ({a_de, a_sof, a_eol} !== 3'b000) begin n_bad++; $display("FAIL rst_a_flags got %b want 000", {a_de, a_sof, a_eol}); end
        n_cmp++; if ({a_mode, a_frame_cnt} !== 10'd0) begin n_bad++; $display("FAIL rst_a_mode_fc got %0d/%0d want 0/0", a_mode, a_frame_cnt); end
        n_cmp++; if ({a_hsync, a_vsync} !== 2'b11) begin n_bad++; $display("FAIL rst_a_sync got %b want 11", {a_hsync, a_vsync}); end
        n_cmp++; if ({b_hsync, b_vsync, b_de} !== 3'b000) begin n_bad++; $display("FAIL rst_b_sync_de got %b want 000", {b_hsync, b_vsync, b_de}); end
        resetn = 1'b1;
        step();
        n_cmp++; if ({a_hcount, a_vcount, a_de, a_sof, a_eol} !== {20'd0, 3'b110}) begin n_bad++; $display("FAIL first_a got h%0d v%0d de%b sof%b eol%b want h0 v0 de1 sof1 eol0", a_hcount, a_vcount, a_de, a_sof, a_eol); end
        n_cmp++; if ({a_mode, a_frame_cnt} !== {2'd1, 8'd0}) begin n_bad++; $display("FAIL first_a_mode_fc got %0d/%0d want 1/0", a_mode, a_frame_cnt); end
        n_cmp++; if ({a_hsync, a_vsync} !== 2'b11) begin n_bad++; $display("FAIL first_a_sync got %b want 11", {a_hsync, a_vsync}); end
        n_cmp++; if ({b_hcount, b_vcount, b_de, b_sof, b_mode, b_frame_cnt} !== {20'd0, 2'b11, 2'd1, 8'd0}) begin n_bad++; $display("FAIL first_b got h%0d v%0d de%b sof%b m%0d fc%0d want 0 0 1 1 1 0", b_hcount, b_vcount, b_de, b_sof, b_mode, b_frame_cnt); end
        en_b = 1'b0;
    endtask

    task automatic test_line();
        int first_low = -1;
        int low_n = 0;
        int bad_h = 0;
        int bad_de = 0;
        int bad_mark = 0;
        for (int i = 0; i < 800; i++) begin
            if (a_hcount !== 10'(i)) bad_h++;
            if (a_de !== (i < 640)) bad_de++;
            if (a_eol !== (i == 799) || a_sof !== (i == 0) || a_vsync !== 1'b1) bad_mark++;
            if (a_hsync === 1'b0) begin
                if (first_low < 0) first_low = i;
                low_n++;
            end
            step();
        end
        n_cmp++; if (bad_h != 0) begin n_bad++; $display("FAIL line_hcount got %0d bad cycles want 0", bad_h); end
        n_cmp++; if (bad_de != 0) begin n_bad++; $display("FAIL line_de got %0d bad cycles want 0", bad_de); end
        n_cmp++; if (bad_mark != 0) begin n_bad++; $display("FAIL line_markers got %0d bad cycles want 0", bad_mark); end
        n_cmp++; if (first_low != 657) begin n_bad++; $display("FAIL hsync_start got %0d want 657", first_low); end
        n_cmp++; if (low_n != 96) begin n_bad++; $display("FAIL hsync_width got %0d want 96", low_n); end
        n_cmp++; if ({a_hcount, a_vcount, a_sof} !== {10'd0, 10'd1, 1'b0}) begin n_bad++; $display("FAIL line_wrap got h%0d v%0d sof%b want h0 v1 sof0", a_hcount, a_vcount, a_sof); end
    endtask

    task automatic test_freeze();
        int bad = 0;
        for (int i = 0; i < 639; i++) step();
        n_cmp++; if (a_hcount !== 10'd639) begin n_bad++; $display("FAIL pre_freeze got %0d want 639", a_hcount); end
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({a_hcount, a_vcount, a_de, a_sof, a_eol, a_hsync, a_vsync} !== {10'd639, 10'd1, 5'b10011}) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL freeze got %0d changed cycles want 0", bad); end
        en_a = 1'b1;
        step();
        n_cmp++; if ({a_hcount, a_de} !== {10'd640, 1'b0}) begin n_bad++; $display("FAIL resume got h%0d de%b want h640 de0", a_hcount, a_de); end
        en_a = 1'b0;
    endtask

    task automatic test_frame();
        int cnt = 0;
        int de_n = 0;
        int eol_n = 0;
        int bad_sync = 0;
        en_b = 1'b1;
        do begin
            de_n += int'(b_de);
            eol_n += int'(b_eol);
            if (b_hsync !== (b_hcount >= 10 && b_hcount <= 12)) bad_sync++;
            if (b_vsync !== (b_vcount >= 7 && b_vcount <= 8)) bad_sync++;
            step();
            cnt++;
        end while (b_sof !== 1'b1 && cnt < 400);
        n_cmp++; if (cnt != 150) begin n_bad++; $display("FAIL frame_len got %0d want 150", cnt); end
        n_cmp++; if (de_n != 48) begin n_bad++; $display("FAIL frame_de got %0d want 48", de_n); end
        n_cmp++; if (eol_n != 10) begin n_bad++; $display("FAIL frame_eol got %0d want 10", eol_n); end
        n_cmp++; if (bad_sync != 0) begin n_bad++; $display("FAIL frame_sync got %0d bad want 0", bad_sync); end
        n_cmp++; if (b_frame_cnt !== 8'd1) begin n_bad++; $display("FAIL frame_cnt1 got %0d want 1", b_frame_cnt); end
    endtask

    task automatic test_mode();
        int n = 0;
        int bad = 0;
        mode_req = 2'd0;
        do begin step(); n++; end while (b_sof !== 1'b1 && n < 400);
        n_cmp++; if ({b_sof, b_mode, b_frame_cnt} !== {1'b1, 2'd0, 8'd2}) begin n_bad++; $display("FAIL mode0 got sof%b m%0d fc%0d want 1 0 2", b_sof, b_mode, b_frame_cnt); end
        n = 0;
        while (b_vcount !== 10'd4 && n < 400) begin step(); n++; end
        mode_req = 2'd2;
        n = 0;
        do begin
            step(); n++;
            if (b_sof !== 1'b1 && b_mode !== 2'd0) bad++;
        end while (b_sof !== 1'b1 && n < 400);
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mode_hold got %0d early changes want 0", bad); end
        n_cmp++; if ({b_sof, b_mode, b_frame_cnt} !== {1'b1, 2'd2, 8'd3}) begin n_bad++; $display("FAIL mode2 got sof%b m%0d fc%0d want 1 2 3", b_sof, b_mode, b_frame_cnt); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (b_vcount !== 10'd3 && n < 400) begin step(); n++; end
        n_cmp++; if (b_vcount !== 10'd3) begin n_bad++; $display("FAIL mid_reach got v%0d want v3", b_vcount); end
        resetn = 1'b0;
        step();
        n_cmp++; if ({b_hcount, b_vcount, b_de, b_sof, b_eol, b_mode, b_frame_cnt, b_hsync, b_vsync} !== 35'd0) begin n_bad++; $display("FAIL mid_reset got h%0d v%0d de%b sof%b m%0d fc%0d", b_hcount, b_vcount, b_de, b_sof, b_mode, b_frame_cnt); end
        resetn = 1'b1;
        step();
        n_cmp++; if ({b_hcount, b_vcount, b_de, b_sof, b_mode, b_frame_cnt} !== {20'd0, 2'b11, 2'd2, 8'd0}) begin n_bad++; $display("FAIL mid_restart got h%0d v%0d de%b sof%b m%0d fc%0d want 0 0 1 1 2 0", b_hcount, b_vcount, b_de, b_sof, b_mode, b_frame_cnt); end
        n = 0;
        do begin step(); n++; end while (b_sof !== 1'b1 && n < 400);
        n_cmp++; if ({n, b_frame_cnt} !== {32'd150, 8'd1}) begin n_bad++; $display("FAIL mid_next got len%0d fc%0d want 150 1", n, b_frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_freeze();
        test_frame();
        test_mode();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
